// File: rtl/des_sched_pkg.sv
// Shared encodings for the region scheduler and the message-counter lanes.
package des_sched_pkg;

  // Region-select width used by the lanes unless overridden.
  localparam int DES_N = 16;

  // Global campaign state codes.
  localparam logic [1:0] GS_IDLE  = 2'd0;
  localparam logic [1:0] GS_LOAD  = 2'd1;
  localparam logic [1:0] GS_ISSUE = 2'd2;
  localparam logic [1:0] GS_DRAIN = 2'd3;

  // Per-lane slot state codes.
  localparam logic [1:0] SS_FREE   = 2'd0;
  localparam logic [1:0] SS_ARMED  = 2'd1;
  localparam logic [1:0] SS_RUN    = 2'd2;
  localparam logic [1:0] SS_RETIRE = 2'd3;

  typedef enum logic [1:0] {
    G_IDLE  = GS_IDLE,
    G_LOAD  = GS_LOAD,
    G_ISSUE = GS_ISSUE,
    G_DRAIN = GS_DRAIN
  } gstate_t;

  typedef enum logic [1:0] {
    S_FREE   = SS_FREE,
    S_ARMED  = SS_ARMED,
    S_RUN    = SS_RUN,
    S_RETIRE = SS_RETIRE
  } slot_t;

endpackage

// File: rtl/des_region_scheduler_if.sv
// Host and lane-facing signal bundle of the region scheduler.
interface des_region_scheduler_if
  import des_sched_pkg::*;
#(
  parameter int N         = DES_N,
  parameter int NUM_UNITS = 4
);
  logic                     start;
  logic                     abort;
  logic [N-1:0]             region_first;
  logic [N-1:0]             region_last;
  logic [NUM_UNITS-1:0]     pause_req;
  logic [NUM_UNITS-1:0]     unit_done;
  logic [NUM_UNITS-1:0]     unit_start;
  logic [NUM_UNITS-1:0]     unit_pause;
  logic [NUM_UNITS-1:0]     unit_reset_counter;
  logic [NUM_UNITS*N-1:0]   unit_region;
  logic                     busy;
  logic                     all_done;
  logic                     cfg_error;
  logic [N:0]               regions_issued;

  // Host / lane side drives requests and observes scheduler outputs.
  modport master (
    output start, abort, region_first, region_last, pause_req, unit_done,
    input  unit_start, unit_pause, unit_reset_counter, unit_region,
           busy, all_done, cfg_error, regions_issued
  );

  // Scheduler side.
  modport slave (
    input  start, abort, region_first, region_last, pause_req, unit_done,
    output unit_start, unit_pause, unit_reset_counter, unit_region,
           busy, all_done, cfg_error, regions_issued
  );
endinterface

// File: rtl/des_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after the pointer.
module des_rr_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int PW        = 2
) (
  input  logic [NUM_UNITS-1:0] req_i,
  input  logic [PW-1:0]        ptr_i,
  output logic [NUM_UNITS-1:0] grant_o,
  output logic                 valid_o
);

  function automatic int wrapIdx(input int base, input int k);
    int s;
    s = base + k;
    if (s >= NUM_UNITS) s = s - NUM_UNITS;
    return s;
  endfunction

  // Walk the lanes starting at the pointer and take the first request seen.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      for (int j = 0; j < NUM_UNITS; j++) begin
        if (!valid_o && req_i[j] && (j == wrapIdx(int'(ptr_i), k))) begin
          grant_o[j] = 1'b1;
          valid_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/des_region_scheduler.sv
// Campaign controller handing consecutive regions to idle DES counter lanes.
module des_region_scheduler
  import des_sched_pkg::*;
#(
  parameter int N         = DES_N,
  parameter int NUM_UNITS = 4
) (
  input logic                clk,
  input logic                rst,
  des_region_scheduler_if.slave sched_if
);

  localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  gstate_t                state_q, state_d;
  slot_t                  slot_q [NUM_UNITS];
  slot_t                  slot_d [NUM_UNITS];
  logic [N:0]             nextRegion_q, nextRegion_d;
  logic [N:0]             endRegion_q, endRegion_d;
  logic [N:0]             regionInc;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          grantIdx;
  logic [NUM_UNITS-1:0]   req, grant;
  logic                   grantValid;
  logic                   startOk, startBad, abortHit, issueEn, allFree;

  logic [NUM_UNITS-1:0]   unitStart_q, unitPause_q, unitReset_q;
  logic [NUM_UNITS*N-1:0] unitRegion_q;
  logic                   busy_q, allDone_q, cfgError_q;
  logic [N:0]             regionsIssued_q;

  // Bounds are captured on the accepting start edge, so LOAD can already grant
  // and the first lane start appears two cycles after the start pulse.
  assign startOk   = sched_if.start && (state_q == G_IDLE) &&
                     (sched_if.region_last >= sched_if.region_first);
  assign startBad  = sched_if.start && (state_q == G_IDLE) &&
                     (sched_if.region_last < sched_if.region_first);
  assign abortHit  = sched_if.abort && (state_q != G_IDLE);
  assign issueEn   = ((state_q == G_LOAD) || (state_q == G_ISSUE)) && !abortHit;
  assign regionInc = nextRegion_q + 1'b1;

  // Request vector and all-free detection from the slot states.
  always_comb begin
    req     = '0;
    allFree = 1'b1;
    for (int i = 0; i < NUM_UNITS; i++) begin
      req[i] = issueEn && (slot_q[i] == S_FREE);
      if (slot_q[i] != S_FREE) allFree = 1'b0;
    end
  end

  des_rr_arbiter #(.NUM_UNITS(NUM_UNITS), .PW(PW)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .valid_o (grantValid)
  );

  // Encode the one-hot grant so the pointer can move past the granted lane.
  always_comb begin
    grantIdx = '0;
    for (int j = 0; j < NUM_UNITS; j++) begin
      if (grant[j]) grantIdx = PW'(j);
    end
  end

  // Global campaign next-state logic.
  always_comb begin
    state_d      = state_q;
    nextRegion_d = nextRegion_q;
    endRegion_d  = endRegion_q;
    ptr_d        = ptr_q;
    case (state_q)
      G_IDLE: begin
        if (startOk) begin
          state_d      = G_LOAD;
          nextRegion_d = {1'b0, sched_if.region_first};
          endRegion_d  = {1'b0, sched_if.region_last};
        end
      end
      G_LOAD, G_ISSUE: begin
        if (abortHit) begin
          state_d = G_IDLE;
        end else begin
          state_d = G_ISSUE;
          if (grantValid) begin
            nextRegion_d = regionInc;
            ptr_d = (grantIdx == PW'(NUM_UNITS - 1)) ? '0 : grantIdx + 1'b1;
            if (regionInc > endRegion_q) state_d = G_DRAIN;
          end
        end
      end
      G_DRAIN: begin
        if (abortHit || allFree) state_d = G_IDLE;
      end
      default: state_d = G_IDLE;
    endcase
  end

  // Per-lane slot next-state: grant arms, done retires, abort retires live lanes.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        S_FREE:   if (grant[i]) slot_d[i] = S_ARMED;
        S_ARMED:  slot_d[i] = abortHit ? S_RETIRE : S_RUN;
        S_RUN:    if (abortHit || sched_if.unit_done[i]) slot_d[i] = S_RETIRE;
        S_RETIRE: slot_d[i] = S_FREE;
        default:  slot_d[i] = S_FREE;
      endcase
    end
  end

  // State, slot and counter registers plus registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= G_IDLE;
      nextRegion_q    <= '0;
      endRegion_q     <= '0;
      ptr_q           <= '0;
      unitStart_q     <= '0;
      unitPause_q     <= '0;
      unitReset_q     <= '0;
      unitRegion_q    <= '0;
      busy_q          <= 1'b0;
      allDone_q       <= 1'b0;
      cfgError_q      <= 1'b0;
      regionsIssued_q <= '0;
      for (int i = 0; i < NUM_UNITS; i++) slot_q[i] <= S_FREE;
    end else begin
      state_q      <= state_d;
      nextRegion_q <= nextRegion_d;
      endRegion_q  <= endRegion_d;
      ptr_q        <= ptr_d;
      for (int i = 0; i < NUM_UNITS; i++) begin
        slot_q[i]      <= slot_d[i];
        unitStart_q[i] <= (slot_d[i] == S_ARMED);
        unitReset_q[i] <= (slot_d[i] == S_RETIRE);
        unitPause_q[i] <= sched_if.pause_req[i] && (slot_d[i] == S_RUN);
        if (grant[i]) unitRegion_q[i*N +: N] <= nextRegion_q[N-1:0];
      end
      busy_q     <= (state_d != G_IDLE);
      cfgError_q <= startBad;
      if (startOk) begin
        allDone_q <= 1'b0;
      end else if ((state_q == G_DRAIN) && (state_d == G_IDLE) && !abortHit) begin
        allDone_q <= 1'b1;
      end
      if (startOk) begin
        regionsIssued_q <= '0;
      end else if (grantValid) begin
        regionsIssued_q <= regionsIssued_q + 1'b1;
      end
    end
  end

  assign sched_if.unit_start         = unitStart_q;
  assign sched_if.unit_pause         = unitPause_q;
  assign sched_if.unit_reset_counter = unitReset_q;
  assign sched_if.unit_region        = unitRegion_q;
  assign sched_if.busy               = busy_q;
  assign sched_if.all_done           = allDone_q;
  assign sched_if.cfg_error          = cfgError_q;
  assign sched_if.regions_issued     = regionsIssued_q;

endmodule
